frequency_detector: RTL and testbench



---
 rtl/frequency_detector.sv | 85 ++++++++
 tb/tb_frequency_detector.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/frequency_detector.sv
// Counts rising midline crossings (with hysteresis) of an 8-bit offset-binary stream
// over a fixed gate window; with a 32000-sample window the count is the frequency in Hz.
module frequency_detector #(
  parameter int GATE_CYCLES = 32000,
  parameter int MIDPOINT    = 128,
  parameter int HYST        = 8
) (
  input  logic        CLK_32KHz,
  input  logic        reset,
  input  logic [7:0]  inputSample,
  output logic [13:0] outputFrequency,
  output logic        frequencyValid,
  output logic        signalPresent
);

  // state      | meaning
  // ST_UNKNOWN | no decisive sample seen since reset
  // ST_LOW     | last decisive sample was at or below the low threshold
  // ST_HIGH    | last decisive sample was at or above the high threshold
  typedef enum logic [1:0] {ST_UNKNOWN, ST_LOW, ST_HIGH} cmp_state_t;

  localparam logic [8:0]  LO_TH     = 9'(MIDPOINT - HYST);
  localparam logic [8:0]  HI_TH     = 9'(MIDPOINT + HYST);
  localparam logic [15:0] GATE_LAST = 16'(GATE_CYCLES - 1);
  localparam logic [13:0] CNT_MAX   = 14'h3FFF;

  cmp_state_t  cmp_state, cmp_next;
  logic [8:0]  sample_ext;
  logic        crossing;
  logic [15:0] gate_cnt;
  logic [13:0] cross_cnt, cross_cnt_inc;
  logic        window_close;

  assign sample_ext = {1'b0, inputSample};

  always_comb begin
    cmp_next = cmp_state;
    crossing = 1'b0;
    case (cmp_state)
      ST_UNKNOWN: begin
        if (sample_ext <= LO_TH)      cmp_next = ST_LOW;
        else if (sample_ext >= HI_TH) cmp_next = ST_HIGH;
      end
      ST_LOW: begin
        if (sample_ext >= HI_TH) begin
          cmp_next = ST_HIGH;
          crossing = 1'b1;
        end
      end
      ST_HIGH: begin
        if (sample_ext <= LO_TH) cmp_next = ST_LOW;
      end
      default: cmp_next = ST_UNKNOWN;
    endcase
  end

  // Saturating increment so an overlong window reports full scale instead of wrapping.
  assign cross_cnt_inc = (crossing && cross_cnt != CNT_MAX) ? cross_cnt + 14'd1 : cross_cnt;
  assign window_close  = (gate_cnt == GATE_LAST);

  always_ff @(posedge CLK_32KHz) begin
    if (reset) begin
      cmp_state       <= ST_UNKNOWN;
      gate_cnt        <= '0;
      cross_cnt       <= '0;
      outputFrequency <= '0;
      frequencyValid  <= 1'b0;
      signalPresent   <= 1'b0;
    end else begin
      cmp_state <= cmp_next;
      if (window_close) begin
        gate_cnt        <= '0;
        cross_cnt       <= '0;
        outputFrequency <= cross_cnt_inc;
        frequencyValid  <= 1'b1;
        signalPresent   <= (cross_cnt_inc != 14'd0);
      end else begin
        gate_cnt       <= gate_cnt + 16'd1;
        cross_cnt      <= cross_cnt_inc;
        frequencyValid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_frequency_detector.sv
// Randomized and directed bench for frequency_detector against a window-level reference
// model; a second long-window instance exercises count saturation.
module tb_frequency_detector;

  localparam int G     = 64;
  localparam int G_SAT = 33000;
  localparam int LO    = 128 - 8;
  localparam int HI    = 128 + 8;

  logic        CLK_32KHz = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  inputSample = '0;
  logic [13:0] outputFrequency;
  logic        frequencyValid, signalPresent;

  logic        sat_reset = 1'b1;
  logic [7:0]  sat_sample = '0;
  logic [13:0] sat_freq;
  logic        sat_valid, sat_present;

  frequency_detector #(.GATE_CYCLES(G)) dut (
    .CLK_32KHz(CLK_32KHz), .reset(reset), .inputSample(inputSample),
    .outputFrequency(outputFrequency), .frequencyValid(frequencyValid),
    .signalPresent(signalPresent)
  );

  frequency_detector #(.GATE_CYCLES(G_SAT)) dut_sat (
    .CLK_32KHz(CLK_32KHz), .reset(sat_reset), .inputSample(sat_sample),
    .outputFrequency(sat_freq), .frequencyValid(sat_valid),
    .signalPresent(sat_present)
  );

  always #5 CLK_32KHz = ~CLK_32KHz;

  int n_vec = 0;
  int n_miss = 0;
  int cyc = 0;

  // Reference model: last decisive side (-1 none, 0 low, 1 high) and a per-window tally.
  int m_side = -1;
  int m_pos = 0;
  int m_tally = 0;
  int m_freq = 0;
  int m_valid = 0;
  int m_present = 0;

  int pulses = 0;
  int last_freq = 0;
  int last_present = 0;
  int sat_pulses = 0;
  int sat_last = 0;
  int sat_last_present = 0;

  task automatic check_val(input string tag, input int obs, input int exp);
    n_vec++;
    if (obs != exp) begin
      n_miss++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_edge(input int s, input bit r);
    if (r) begin
      m_side = -1; m_pos = 0; m_tally = 0;
      m_freq = 0; m_valid = 0; m_present = 0;
    end else begin
      if (m_side == 0 && s >= HI) m_tally = (m_tally + 1 > 16383) ? 16383 : m_tally + 1;
      if (s <= LO)      m_side = 0;
      else if (s >= HI) m_side = 1;
      m_pos++;
      if (m_pos == G) begin
        m_freq = m_tally; m_valid = 1; m_present = (m_tally != 0);
        m_tally = 0; m_pos = 0;
      end else begin
        m_valid = 0;
      end
    end
  endtask

  task automatic step(input int s, input bit r);
    inputSample = 8'(s);
    reset       = r;
    sat_sample  = cyc[0] ? 8'd255 : 8'd0;
    sat_reset   = (cyc < 2);
    @(posedge CLK_32KHz);
    #1;
    cyc++;
    model_edge(s, r);
    check_val("valid", int'(frequencyValid), m_valid);
    check_val("freq", int'(outputFrequency), m_freq);
    check_val("present", int'(signalPresent), m_present);
    if (frequencyValid) begin
      pulses++; last_freq = outputFrequency; last_present = signalPresent;
    end
    if (sat_valid) begin
      sat_pulses++; sat_last = sat_freq; sat_last_present = sat_present;
    end
  endtask

  function automatic int square(input int i, input int half);
    return ((i / half) % 2) ? 255 : 0;
  endfunction

  initial begin
    int p0, seg, kind, half, len;

    // Reset with random samples: outputs must stay zero.
    for (int i = 0; i < 5; i++) step($urandom_range(0, 255), 1'b1);
    check_val("rst_freq", int'(outputFrequency), 0);
    check_val("rst_valid", int'(frequencyValid), 0);

    // Midline constant: one pulse exactly G cycles after release, count 0.
    p0 = pulses;
    for (int i = 0; i < G - 1; i++) step(128, 1'b0);
    check_val("const_early_pulse", pulses - p0, 0);
    step(128, 1'b0);
    check_val("const_pulse_at_G", int'(frequencyValid), 1);
    check_val("const_freq", last_freq, 0);
    check_val("const_present", last_present, 0);
    step(128, 1'b0);
    check_val("valid_one_cycle", int'(frequencyValid), 0);

    // 8/8 square wave: period 16 -> G/16 crossings per window, exactly.
    step(0, 1'b1);
    for (int i = 0; i < 2 * G; i++) begin
      step(square(i, 8), 1'b0);
      if (i == G - 1) begin
        check_val("sq_win1", last_freq, G / 16);
        check_val("sq_present", last_present, 1);
      end
    end
    check_val("sq_win2", last_freq, G / 16);

    // Hysteresis: inside-band toggling counts nothing; just-outside toggling counts every period.
    step(0, 1'b1);
    for (int i = 0; i < G; i++) step(i[0] ? 135 : 121, 1'b0);
    check_val("hyst_inside", last_freq, 0);
    for (int i = 0; i < 2 * G; i++) step(i[0] ? 136 : 120, 1'b0);
    check_val("hyst_edge", last_freq, G / 2);

    // Mid-window reset discards the partial window; next pulse G cycles after release.
    step(0, 1'b1);
    for (int i = 0; i < G / 2; i++) step(square(i, 8), 1'b0);
    step(0, 1'b1);
    p0 = pulses;
    for (int i = 0; i < G - 1; i++) step(square(i, 8), 1'b0);
    check_val("midrst_no_pulse", pulses - p0, 0);
    step(square(G - 1, 8), 1'b0);
    check_val("midrst_pulse", pulses - p0, 1);
    check_val("midrst_freq_ok", int'(last_freq >= G / 16 - 1 && last_freq <= G / 16 + 1), 1);

    // Random segments until the saturation instance has closed its window.
    seg = 0;
    while (cyc < G_SAT + 100) begin
      kind = $urandom_range(0, 3);
      half = $urandom_range(1, 20);
      len  = $urandom_range(G / 2, 3 * G);
      for (int i = 0; i < len; i++) begin
        case (kind)
          0: step($urandom_range(0, 255), ($urandom_range(0, 199) == 0));
          1: step(square(i, half), 1'b0);
          2: step(((i / half) % 2) ? $urandom_range(HI - 2, 255) : $urandom_range(0, LO + 2), 1'b0);
          default: step($urandom_range(LO - 1, HI + 1), 1'b0);
        endcase
      end
      seg++;
    end

    check_val("sat_pulses", sat_pulses, 1);
    check_val("sat_freq", sat_last, 16383);
    check_val("sat_present", sat_last_present, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
